// File: rtl/mux4_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux4_arb_pkg
// Shared types and helpers for the four-way round-robin mux arbiter.
//   arb_state_t : arbiter FSM state (IDLE / GRANT)
//   NREQ        : number of requesters sharing the mux
//   req_idx_t   : binary requester index, also the mux select encoding
//   HOLD_W      : width of the tenure counter (MAX_HOLD is at most 255)
//   idx_to_onehot() : binary requester index to one-hot grant vector
// ---------------------------------------------------------------------------
package mux4_arb_pkg;

    typedef enum logic [0:0] {IDLE, GRANT} arb_state_t;

    localparam int NREQ   = 4;
    localparam int HOLD_W = 8;

    typedef logic [1:0] req_idx_t;

    function automatic logic [NREQ-1:0] idx_to_onehot(input req_idx_t idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4.sv
// ---------------------------------------------------------------------------
// mux4
// Plain 4:1 combinational data multiplexer.
//   sel        in  2      binary select
//   d0..d3     in  WIDTH  data inputs
//   y          out WIDTH  selected input
// ---------------------------------------------------------------------------
module mux4 #(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set request bit when
// scanning ptr, ptr+1, ... modulo 4.
//   req    in  4  candidate request bits
//   ptr    in  2  scan start index (highest priority)
//   found  out 1  at least one request bit is set
//   idx    out 2  index of the winning request (ptr when none found)
// ---------------------------------------------------------------------------
module rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  req_idx_t        ptr,
    output logic            found,
    output req_idx_t        idx
);

    req_idx_t cand;

    // Scan from the farthest offset back to ptr so that the nearest set bit
    // is the last one written and therefore wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + req_idx_t'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter sharing one 4-input mux between four requesters. The
// owner is held in a registered one-hot grant that also drives the mux
// select; an owner may keep the mux at most MAX_HOLD consecutive cycles
// while another requester is waiting.
//
// Build option: define ARB_LOCK_EN to let the owner suppress the tenure
// limit by holding lock=1. Without it, lock is accepted but ignored.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high reset
//   req      in   4      level requests, held until done
//   lock     in   1      owner tenure lock (ARB_LOCK_EN builds only)
//   d0..d3   in   WIDTH  requester data buses
//   grant    out  4      registered one-hot grant, zero when idle
//   sel      out  2      registered mux select (owner index)
//   y        out  WIDTH  selected data, combinational from sel
//   y_valid  out  1      registered, equals |grant
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             lock,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [NREQ-1:0]  grant,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state, state_n;
    req_idx_t          ptr, ptr_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [NREQ-1:0]   grant_n;
    req_idx_t          sel_n;

    logic              pick_found;
    req_idx_t          pick_idx;
    logic              owner_req;
    logic              expired;
    logic              locked;
    logic              take;

`ifdef ARB_LOCK_EN
    assign locked = lock;
`else
    logic lock_unused;
    assign lock_unused = lock;
    assign locked      = 1'b0;
`endif

    // The current owner is excluded from the candidates: in IDLE grant is
    // zero so all requests compete; in GRANT only the others do, which is
    // exactly what a drop or an expiry hand-over needs.
    rr_pick u_pick (
        .req   (req & ~grant),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req = |(req & grant);
    assign expired   = (hold_cnt == HOLD_LAST);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        grant_n = grant;
        sel_n   = sel;
        take    = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) take = 1'b1;
            end
            GRANT: begin
                if (!owner_req) begin
                    // A drop takes precedence over a simultaneous expiry.
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        hold_n  = '0;
                    end
                end else if (expired && pick_found && !locked) begin
                    take = 1'b1;
                end else if (!expired) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                hold_n  = '0;
            end
        endcase

        if (take) begin
            state_n = GRANT;
            grant_n = idx_to_onehot(pick_idx);
            sel_n   = pick_idx;
            ptr_n   = pick_idx + 1'b1;
            hold_n  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            sel      <= '0;
            y_valid  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            grant    <= grant_n;
            sel      <= sel_n;
            y_valid  <= |grant_n;
        end
    end

    mux4 #(.WIDTH(WIDTH)) u_mux (
        .sel (sel),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .y   (y)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Directed bench for mux4_rr_arbiter (WIDTH=4, MAX_HOLD=8). Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point,
// i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       lock;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [3:0] y;
    logic       y_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .lock    (lock),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .grant   (grant),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    logic [3:0] rot_exp [5];
    logic [1:0] rot_sel [5];
    logic [3:0] rot_y   [5];

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        lock  = 1'b0;
        d0 = 4'h3; d1 = 4'h5; d2 = 4'h0; d3 = 4'hC;
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rot_y   = '{4'h3, 4'h5, 4'hA, 4'hC, 4'h3};
        #1;

        // T1: reset held two cycles with every request high
        req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t1_rst_grant", grant, 4'b0000);
            check("t1_rst_sel", sel, 2'd0);
            check("t1_rst_valid", y_valid, 1'b0);
        end
        reset = 1'b0;
        tick();
        check("t1_first_grant", grant, 4'b0001);
        check("t1_first_valid", y_valid, 1'b1);
        req = 4'b0000;
        tick();
        check("t1_idle_grant", grant, 4'b0000);

        // T2: single requester
        d2  = 4'hA;
        req = 4'b0100;
        tick();
        check("t2_grant", grant, 4'b0100);
        check("t2_sel", sel, 2'd2);
        check("t2_y", y, 4'hA);
        check("t2_valid", y_valid, 1'b1);
        req = 4'b0000;
        tick();
        check("t2_drop_grant", grant, 4'b0000);
        check("t2_drop_valid", y_valid, 1'b0);

        // T3: rotation, each owner drops for its granted cycle only
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_rot_grant", grant, rot_exp[i]);
            check("t3_rot_sel", sel, rot_sel[i]);
            check("t3_rot_y", y, rot_y[i]);
            check("t3_rot_valid", y_valid, 1'b1);
            req = ~rot_exp[i];
        end

        // T4: tenure limit, owner 0 keeps req while requester 1 waits
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t4_hold_grant0", grant, 4'b0001);
        end
        tick();
        check("t4_preempt_grant1", grant, 4'b0010);
        check("t4_preempt_sel", sel, 2'd1);

`ifdef ARB_LOCK_EN
        // T5: lock suppresses the tenure limit
        do_reset();
        lock = 1'b1;
        req  = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_locked_grant0", grant, 4'b0001);
        end
        lock = 1'b0;
        tick();
        check("t5_unlock_grant1", grant, 4'b0010);
`endif

        // T6: reset in the middle of a tenure
        do_reset();
        req = 4'b1000;
        tick();
        check("t6_owner3", grant, 4'b1000);
        reset = 1'b1;
        req   = 4'b1001;
        tick();
        check("t6_rst_grant", grant, 4'b0000);
        check("t6_rst_sel", sel, 2'd0);
        check("t6_rst_valid", y_valid, 1'b0);
        reset = 1'b0;
        tick();
        check("t6_ptr0_grant", grant, 4'b0001);
        check("t6_ptr0_y", y, 4'h3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
